// File: rtl/csi_pkg.sv
// Shared CSI-2 definitions: data-type constants, header ECC column table and parity function.
// Used by both the receive-side checker and the transmit-side ECC generator.
package csi_pkg;

  localparam logic [5:0] DT_FRAME_START = 6'h00;
  localparam logic [5:0] DT_FRAME_END   = 6'h01;
  localparam logic [5:0] DT_LINE_START  = 6'h02;
  localparam logic [5:0] DT_LINE_END    = 6'h03;
  localparam logic [5:0] DT_RAW8        = 6'h2A;
  localparam logic [5:0] DT_RAW10       = 6'h2B;
  localparam logic [5:0] DT_RAW12       = 6'h2C;

  localparam logic [5:0] SHORT_DT_MAX_DEF = 6'h0F;

  // Parity contribution of each packet-header bit 0..23 to ECC[5:0].
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PLD,
    S_FTR
  } state_e;

  function automatic logic [5:0] ecc_parity(input logic [23:0] ph);
    logic [5:0] p;
    p = '0;
    for (int i = 0; i < 24; i++) begin
      if (ph[i]) p ^= ECC_COL[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/csi_ecc_syndrome.sv
// Combinational header ECC check: syndrome, single-bit correction and uncorrectable flag.
module csi_ecc_syndrome
  import csi_pkg::*;
(
  input  logic [23:0] ph,
  input  logic [5:0]  ecc,
  output logic [23:0] ph_corr,
  output logic        corr,
  output logic        err
);

  logic [5:0] syn;

  // NOTE: every output gets a default before any condition so no latch is inferred.
  always_comb begin
    syn     = ecc ^ ecc_parity(ph);
    ph_corr = ph;
    corr    = 1'b0;
    err     = 1'b0;
    if (syn != 6'd0) begin
      // A single-bit syndrome points at a flipped ECC bit; the header data is intact.
      corr = $onehot(syn);
      for (int i = 0; i < 24; i++) begin
        if (syn == ECC_COL[i]) begin
          ph_corr[i] = ~ph[i];
          corr       = 1'b1;
        end
      end
      err = ~corr;
    end
  end

endmodule

// File: rtl/csi_hdr_ecc_check.sv
// CSI-2 receive header parser: captures DI/WC/ECC, corrects or drops the header,
// then forwards long-packet payload and the 2-byte CRC footer.
module csi_hdr_ecc_check
  import csi_pkg::*;
#(
  parameter int         CNT_W        = 16,
  parameter logic [5:0] SHORT_DT_MAX = SHORT_DT_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             pkt_start,
  output logic             hdr_valid,
  output logic [1:0]       hdr_vc,
  output logic [5:0]       hdr_dt,
  output logic [15:0]      hdr_wc,
  output logic             hdr_long,
  output logic             ecc_corr,
  output logic             ecc_err,
  output logic             pld_valid,
  output logic [7:0]       pld_data,
  output logic             pld_last,
  output logic             crc_valid,
  output logic [15:0]      crc_rx,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_err
);

  state_e      state_q, state_d;
  logic [1:0]  idx_q;
  logic [7:0]  di_q, wc_lo_q, wc_hi_q, crc_lo_q;
  logic [15:0] pld_cnt_q;

  logic [23:0] ph_corr;
  logic        syn_corr, syn_err;
  logic [15:0] wc_c;
  logic [5:0]  dt_c;
  logic        long_c;

  csi_ecc_syndrome u_syndrome (
    .ph      ({wc_hi_q, wc_lo_q, di_q}),
    .ecc     (byte_data[5:0]),
    .ph_corr (ph_corr),
    .corr    (syn_corr),
    .err     (syn_err)
  );

  assign wc_c   = ph_corr[23:8];
  assign dt_c   = ph_corr[5:0];
  assign long_c = dt_c > SHORT_DT_MAX;
  assign busy   = state_q != S_IDLE;

  always_comb begin
    state_d = state_q;
    if (byte_valid) begin
      if (pkt_start) begin
        state_d = S_HDR;
      end else begin
        unique case (state_q)
          S_HDR: if (idx_q == 2'd3) begin
            if (syn_err || !long_c) state_d = S_IDLE;
            else if (wc_c == 16'd0)  state_d = S_FTR;
            else                     state_d = S_PLD;
          end
          S_PLD:   if (pld_cnt_q == 16'd1) state_d = S_FTR;
          S_FTR:   if (idx_q == 2'd1) state_d = S_IDLE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      di_q      <= '0;
      wc_lo_q   <= '0;
      wc_hi_q   <= '0;
      crc_lo_q  <= '0;
      pld_cnt_q <= '0;
      hdr_valid <= 1'b0;
      hdr_vc    <= '0;
      hdr_dt    <= '0;
      hdr_wc    <= '0;
      hdr_long  <= 1'b0;
      ecc_corr  <= 1'b0;
      ecc_err   <= 1'b0;
      pld_valid <= 1'b0;
      pld_data  <= '0;
      pld_last  <= 1'b0;
      crc_valid <= 1'b0;
      crc_rx    <= '0;
      cnt_corr  <= '0;
      cnt_err   <= '0;
    end else begin
      hdr_valid <= 1'b0;
      ecc_err   <= 1'b0;
      pld_valid <= 1'b0;
      pld_last  <= 1'b0;
      crc_valid <= 1'b0;
      if (byte_valid) begin
        if (pkt_start) begin
          di_q  <= byte_data;
          idx_q <= 2'd1;
        end else begin
          unique case (state_q)
            S_HDR: begin
              unique case (idx_q)
                2'd1: begin
                  wc_lo_q <= byte_data;
                  idx_q   <= 2'd2;
                end
                2'd2: begin
                  wc_hi_q <= byte_data;
                  idx_q   <= 2'd3;
                end
                default: begin
                  idx_q     <= 2'd0;
                  pld_cnt_q <= wc_c;
                  if (syn_err) begin
                    ecc_err <= 1'b1;
                    if (!(&cnt_err)) cnt_err <= cnt_err + 1'b1;
                  end else begin
                    hdr_valid <= 1'b1;
                    hdr_vc    <= ph_corr[7:6];
                    hdr_dt    <= dt_c;
                    hdr_wc    <= wc_c;
                    hdr_long  <= long_c;
                    ecc_corr  <= syn_corr;
                    if (syn_corr && !(&cnt_corr)) cnt_corr <= cnt_corr + 1'b1;
                  end
                end
              endcase
            end
            S_PLD: begin
              pld_valid <= 1'b1;
              pld_data  <= byte_data;
              pld_last  <= pld_cnt_q == 16'd1;
              pld_cnt_q <= pld_cnt_q - 1'b1;
            end
            S_FTR: begin
              // Footer arrives LSB first; idx_q tracks which half has been seen.
              if (idx_q == 2'd0) begin
                crc_lo_q <= byte_data;
                idx_q    <= 2'd1;
              end else begin
                crc_rx    <= {byte_data, crc_lo_q};
                crc_valid <= 1'b1;
                idx_q     <= 2'd0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
